// File: rtl/seg7_scan_decoder.sv
// Receive-side monitor for a multiplexed 7-segment bus: waits for each scan slot to settle,
// decodes the cathode pattern and rebuilds the per-position digit register.
module seg7_scan_decoder #(
    parameter int NDIG       = 8,
    parameter int STABLE_CYC = 4,
    parameter int CNT_W      = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NDIG-1:0]   anode,
    input  logic [7:0]        cathode,
    output logic [4*NDIG-1:0] digits,
    output logic [NDIG-1:0]   valid_mask,
    output logic              frame_done,
    output logic              bad_pattern,
    output logic [7:0]        err_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYC);
    localparam logic [CNT_W-1:0] CNT_ARM = CNT_W'(STABLE_CYC - 1);

    logic [NDIG-1:0]   a_q, a_p;
    logic [7:0]        c_q, c_p;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [NDIG-1:0]   seen_q, seen_d;
    logic [4*NDIG-1:0] digits_q, digits_d;
    logic [NDIG-1:0]   valid_q, valid_d;
    logic              frame_q, frame_d;
    logic              bad_q, bad_d;
    logic [7:0]        err_q, err_d;

    logic              found, multi, one_low;
    logic              stable, capture;
    logic [NDIG-1:0]   sel, seen_next;
    logic [3:0]        code;
    logic              code_bad;

    // Input sample stage plus a one-deep history for the stability compare.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q <= '0;
            c_q <= '0;
            a_p <= '0;
            c_p <= '0;
        end else begin
            a_q <= anode;
            c_q <= cathode;
            a_p <= a_q;
            c_p <= c_q;
        end
    end

    assign sel = ~a_q;

    always_comb begin
        found = 1'b0;
        multi = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            if (sel[i]) begin
                if (found) multi = 1'b1;
                found = 1'b1;
            end
        end
        one_low = found && !multi;
    end

    assign stable  = one_low && ({a_q, c_q} == {a_p, c_p});
    assign capture = stable && (cnt_q == CNT_ARM);

    always_comb begin
        code     = 4'hE;
        code_bad = 1'b0;
        case (c_q)
            8'h03:   code = 4'h0;
            8'h9F:   code = 4'h1;
            8'h25:   code = 4'h2;
            8'h0D:   code = 4'h3;
            8'h99:   code = 4'h4;
            8'h49:   code = 4'h5;
            8'h41:   code = 4'h6;
            8'h1F:   code = 4'h7;
            8'h01:   code = 4'h8;
            8'h09:   code = 4'h9;
            8'hFE:   code = 4'hA;
            8'hFF:   code = 4'hF;
            default: code_bad = 1'b1;
        endcase
    end

    always_comb begin
        if (!stable) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign seen_next = seen_q | sel;

    always_comb begin
        digits_d = digits_q;
        valid_d  = valid_q;
        seen_d   = seen_q;
        frame_d  = 1'b0;
        bad_d    = 1'b0;
        err_d    = err_q;
        if (capture) begin
            for (int i = 0; i < NDIG; i++) begin
                if (sel[i]) digits_d[4*i +: 4] = code;
            end
            valid_d = valid_q | sel;
            // Completing the set closes the frame and starts the next one empty.
            if (&seen_next) begin
                seen_d  = '0;
                frame_d = 1'b1;
            end else begin
                seen_d = seen_next;
            end
            if (code_bad) begin
                bad_d = 1'b1;
                if (err_q != 8'hFF) err_d = err_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            seen_q   <= '0;
            digits_q <= '1;
            valid_q  <= '0;
            frame_q  <= 1'b0;
            bad_q    <= 1'b0;
            err_q    <= '0;
        end else begin
            cnt_q    <= cnt_d;
            seen_q   <= seen_d;
            digits_q <= digits_d;
            valid_q  <= valid_d;
            frame_q  <= frame_d;
            bad_q    <= bad_d;
            err_q    <= err_d;
        end
    end

    assign digits      = digits_q;
    assign valid_mask  = valid_q;
    assign frame_done  = frame_q;
    assign bad_pattern = bad_q;
    assign err_count   = err_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Bench for seg7_scan_decoder: vector table, directed corner sequences and random slots,
// all checked every cycle against a run-length reference model.
module tb_seg7_scan_decoder;

    localparam int NDIG = 8;
    localparam int STAB = 4;

    logic        clk;
    logic        reset;
    logic [7:0]  anode;
    logic [7:0]  cathode;
    logic [31:0] digits;
    logic [7:0]  valid_mask;
    logic        frame_done;
    logic        bad_pattern;
    logic [7:0]  err_count;

    seg7_scan_decoder #(
        .NDIG       (NDIG),
        .STABLE_CYC (STAB),
        .CNT_W      (3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .anode       (anode),
        .cathode     (cathode),
        .digits      (digits),
        .valid_mask  (valid_mask),
        .frame_done  (frame_done),
        .bad_pattern (bad_pattern),
        .err_count   (err_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_total = 0;
    int n_bad   = 0;
    int frame_cnt = 0;
    int bad_cnt   = 0;

    logic [7:0] pat_tab [12] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49,
                                 8'h41, 8'h1F, 8'h01, 8'h09, 8'hFE, 8'hFF};
    logic [3:0] code_tab [12] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5,
                                  4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hF};

    // Reference model: a slot is captured once its sampled value has repeated STAB+1 times.
    logic [3:0]  m_dig [NDIG];
    logic [7:0]  m_valid, m_seen;
    int          m_err;
    logic        m_frame, m_bad;
    logic [15:0] m_lv;
    int          m_run;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_digits();
        logic [31:0] r;
        for (int i = 0; i < NDIG; i++) r[4*i +: 4] = m_dig[i];
        return r;
    endfunction

    function automatic void m_decode(input logic [7:0] c, output logic [3:0] cd,
                                     output logic bd);
        cd = 4'hE;
        bd = 1'b1;
        for (int k = 0; k < 12; k++) begin
            if (pat_tab[k] == c) begin
                cd = code_tab[k];
                bd = 1'b0;
            end
        end
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NDIG; i++) m_dig[i] = 4'hF;
        m_valid = '0;
        m_seen  = '0;
        m_err   = 0;
        m_frame = 1'b0;
        m_bad   = 1'b0;
        m_lv    = 16'h0000;
        m_run   = 1;
    endtask

    task automatic model_step();
        logic [7:0] an;
        logic [3:0] cd;
        logic       bd;
        int         pos;
        if (reset) begin
            model_reset();
            return;
        end
        m_frame = 1'b0;
        m_bad   = 1'b0;
        an = m_lv[15:8];
        if ($countones(~an) == 1 && m_run == STAB + 1) begin
            pos = 0;
            for (int i = 0; i < NDIG; i++) if (!an[i]) pos = i;
            m_decode(m_lv[7:0], cd, bd);
            m_dig[pos]   = cd;
            m_valid[pos] = 1'b1;
            m_seen[pos]  = 1'b1;
            if (bd) begin
                m_bad = 1'b1;
                if (m_err < 255) m_err++;
            end
            if (m_seen == 8'hFF) begin
                m_seen  = '0;
                m_frame = 1'b1;
            end
        end
        if ({anode, cathode} == m_lv) begin
            if (m_run < 1000) m_run++;
        end else begin
            m_lv  = {anode, cathode};
            m_run = 1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("digits", digits, m_digits());
        check("valid_mask", valid_mask, m_valid);
        check("frame_done", frame_done, m_frame);
        check("bad_pattern", bad_pattern, m_bad);
        check("err_count", err_count, m_err);
        if (frame_done) frame_cnt++;
        if (bad_pattern) bad_cnt++;
    endtask

    task automatic sync_reset();
        reset = 1'b1;
        model_reset();
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic async_reset();
        #1;
        reset = 1'b1;
        model_reset();
        #1;
        check("arst_digits", digits, 32'hFFFFFFFF);
        check("arst_valid", valid_mask, 8'h00);
        check("arst_err", err_count, 8'h00);
        check("arst_pulses", {frame_done, bad_pattern}, 2'b00);
        tick();
        reset = 1'b0;
    endtask

    typedef struct {
        logic [7:0] an;
        logic [7:0] cat;
        logic [3:0] code;
        logic       bad;
    } vec_t;

    vec_t vecs [13];

    initial begin
        vecs[0]  = '{8'hFE, 8'h03, 4'h0, 1'b0};
        vecs[1]  = '{8'hFD, 8'h9F, 4'h1, 1'b0};
        vecs[2]  = '{8'hFB, 8'h25, 4'h2, 1'b0};
        vecs[3]  = '{8'hF7, 8'h0D, 4'h3, 1'b0};
        vecs[4]  = '{8'hEF, 8'h99, 4'h4, 1'b0};
        vecs[5]  = '{8'hDF, 8'h49, 4'h5, 1'b0};
        vecs[6]  = '{8'hBF, 8'h41, 4'h6, 1'b0};
        vecs[7]  = '{8'h7F, 8'h1F, 4'h7, 1'b0};
        vecs[8]  = '{8'hFE, 8'h01, 4'h8, 1'b0};
        vecs[9]  = '{8'hFD, 8'h09, 4'h9, 1'b0};
        vecs[10] = '{8'hFB, 8'hFE, 4'hA, 1'b0};
        vecs[11] = '{8'hF7, 8'hFF, 4'hF, 1'b0};
        vecs[12] = '{8'hEF, 8'h55, 4'hE, 1'b1};

        // Reset held for 5 cycles.
        reset   = 1'b1;
        anode   = 8'hFF;
        cathode = 8'hFF;
        model_reset();
        for (int i = 0; i < 5; i++) tick();
        check("rst_digits", digits, 32'hFFFFFFFF);
        check("rst_valid", valid_mask, 8'h00);
        check("rst_err", err_count, 8'h00);
        reset = 1'b0;

        // Full scan from the vector table, 6 cycles per slot.
        frame_cnt = 0;
        for (int v = 0; v < 13; v++) begin
            anode   = vecs[v].an;
            cathode = vecs[v].cat;
            bad_cnt = 0;
            for (int h = 0; h < 6; h++) tick();
            for (int i = 0; i < NDIG; i++) begin
                if (!vecs[v].an[i]) check("vec_code", digits[4*i +: 4], vecs[v].code);
            end
            check("vec_bad", bad_cnt, vecs[v].bad ? 1 : 0);
            if (v == 7) begin
                check("scan_digits", digits, 32'h76543210);
                check("scan_valid", valid_mask, 8'hFF);
                check("scan_frames", frame_cnt, 1);
            end
        end

        // Short hold gives nothing; a 6-cycle hold captures on exactly its 6th edge.
        anode = 8'hFF;
        tick();
        tick();
        anode   = 8'hF7;
        cathode = 8'h99;
        for (int h = 0; h < 3; h++) tick();
        check("short_hold", digits[15:12], 4'hF);
        cathode = 8'h49;
        for (int h = 0; h < 5; h++) tick();
        check("hold5_nocap", digits[15:12], 4'hF);
        tick();
        check("hold6_cap", digits[15:12], 4'h5);

        // Bad pattern and error saturation.
        sync_reset();
        anode   = 8'hFB;
        cathode = 8'h00;
        bad_cnt = 0;
        for (int h = 0; h < 6; h++) tick();
        check("bad_digit", digits[11:8], 4'hE);
        check("bad_pulses", bad_cnt, 1);
        check("bad_err1", err_count, 8'd1);
        for (int r = 0; r < 299; r++) begin
            anode = 8'hFF;
            tick();
            anode = 8'hFB;
            for (int h = 0; h < 6; h++) tick();
        end
        check("err_sat", err_count, 8'd255);

        // Two-low and all-high anodes never capture.
        bad_cnt   = 0;
        frame_cnt = 0;
        anode   = 8'hFC;
        cathode = 8'h03;
        for (int h = 0; h < 20; h++) tick();
        anode = 8'hFF;
        for (int h = 0; h < 20; h++) tick();
        check("nocap_digits", digits, 32'hFFFFFEFF);
        check("nocap_valid", valid_mask, 8'h04);
        check("nocap_pulses", bad_cnt + frame_cnt, 0);
        check("nocap_err", err_count, 8'd255);

        // Reset in the middle of a dwell, then a full dwell after release.
        anode   = 8'hDF;
        cathode = 8'h41;
        for (int h = 0; h < 3; h++) tick();
        async_reset();
        for (int h = 0; h < 5; h++) tick();
        check("post_rst_wait", digits, 32'hFFFFFFFF);
        tick();
        check("post_rst_cap", digits, 32'hFF6FFFFF);
        check("post_rst_valid", valid_mask, 8'h20);

        // Random slots with occasional async resets.
        for (int s = 0; s < 400; s++) begin
            int r;
            int hold;
            r = $urandom_range(0, 9);
            if (r < 8) anode = ~(8'h01 << $urandom_range(0, 7));
            else if (r == 8) anode = 8'hFF;
            else anode = 8'($urandom);
            if ($urandom_range(0, 9) < 7) cathode = pat_tab[$urandom_range(0, 11)];
            else cathode = 8'($urandom);
            hold = $urandom_range(1, 8);
            for (int h = 0; h < hold; h++) tick();
            if ($urandom_range(0, 49) == 0) async_reset();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
